video_stream_gen: RTL and testbench



---
 rtl/sobel_pkg.sv | 16 +
 rtl/video_timing_cnt.sv | 56 +++++
 rtl/video_stream_gen.sv | 155 +++++++++++++++
 tb/tb_video_stream_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline: pattern selects and the
// video_stream_gen FSM state type.
package sobel_pkg;

  localparam logic [1:0] PAT_RAMP    = 2'd0;
  localparam logic [1:0] PAT_CHECKER = 2'd1;
  localparam logic [1:0] PAT_FLAT    = 2'd2;
  localparam logic [1:0] PAT_BORDER  = 2'd3;

  typedef enum logic [1:0] {
    VSG_IDLE,
    VSG_RUN,
    VSG_DRAIN
  } vsg_state_t;

endpackage

// File: rtl/video_timing_cnt.sv
// Raster h/v counters with sync/de decode and line/frame-end strobes.
// Counters advance only while 'advance' is high; otherwise they hold.
module video_timing_cnt #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hs_act,
  output logic          vs_act,
  output logic          de_act,
  output logic          line_end,
  output logic          frame_end,
  output logic          at_origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Strobes and region decode from the current count
  always_comb begin
    line_end  = (int'(h) == H_TOTAL - 1);
    frame_end = line_end && (int'(v) == V_TOTAL - 1);
    at_origin = (h == '0) && (v == '0);
    hs_act    = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
    vs_act    = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
    de_act    = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  end

  // h wraps each line and carries into v; v wraps each frame
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (advance) begin
      if (line_end) begin
        h <= '0;
        v <= frame_end ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// Raster timing and grayscale test-pattern source.
// Optional build macro VSG_FRAME_CNT_EN adds the frame_cnt port and makes
// the ramp/checker patterns move by one grey level per frame.
module video_stream_gen
  import sobel_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern_sel,
  output logic [7:0] pixel_out,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic       line_start
`ifdef VSG_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  vsg_state_t    state_q, state_d;
  logic          active;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hs_act, vs_act, de_act, line_end, frame_end, at_origin;
  logic [1:0]    pat_q, pat_cur;
  logic [7:0]    line_base;
  logic [7:0]    moving;
  logic [7:0]    pix;
  logic          x_b3, y_b3, on_border;

  video_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst(rst), .advance(active),
    .h(h), .v(v),
    .hs_act(hs_act), .vs_act(vs_act), .de_act(de_act),
    .line_end(line_end), .frame_end(frame_end), .at_origin(at_origin)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= VSG_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a stop request only lands on the frame boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      VSG_IDLE:  if (en) state_d = VSG_RUN;
      VSG_RUN:   if (!en) state_d = VSG_DRAIN;
      VSG_DRAIN: begin
        if (en)             state_d = VSG_RUN;
        else if (frame_end) state_d = VSG_IDLE;
      end
      default:   state_d = VSG_IDLE;
    endcase
  end

  // FSM outputs: counters and pins run in every state but IDLE
  always_comb begin
    active = (state_q != VSG_IDLE);
  end

  // Pattern select is taken live at the origin so the first pixel of a
  // frame already uses it, then held in pat_q for the rest of the frame
  always_comb begin
    pat_cur = at_origin ? pattern_sel : pat_q;
  end

  // Latch the pattern select at the frame origin
  always_ff @(posedge clk) begin
    if (rst)            pat_q <= PAT_RAMP;
    else if (at_origin) pat_q <= pattern_sel;
  end

  // Ramp line base: y*H_ACTIVE mod 256 built by accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base <= '0;
    end else if (active) begin
      if (frame_end)     line_base <= '0;
      else if (line_end) line_base <= line_base + 8'(H_ACTIVE);
    end
  end

`ifdef VSG_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 255
  always_ff @(posedge clk) begin
    if (rst)                      frame_cnt <= '0;
    else if (active && frame_end) frame_cnt <= frame_cnt + 8'd1;
  end

  assign moving = frame_cnt;
`else
  assign moving = '0;
`endif

  // Pattern generation from the current count
  always_comb begin
    x_b3      = ((int'(h) / 8) % 2) == 1;
    y_b3      = ((int'(v) / 8) % 2) == 1;
    on_border = (h == '0) || (int'(h) == H_ACTIVE - 1) ||
                (v == '0) || (int'(v) == V_ACTIVE - 1);
    pix = '0;
    case (pat_cur)
      PAT_RAMP:    pix = line_base + 8'(h) + moving;
      PAT_CHECKER: pix = ((x_b3 ^ y_b3) ? 8'hFF : 8'h00) + moving;
      PAT_FLAT:    pix = 8'h80;
      PAT_BORDER:  pix = on_border ? 8'hFF : 8'h00;
      default:     pix = '0;
    endcase
  end

  // Output registers: one cycle behind the counters, all pins aligned
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      de          <= 1'b0;
      pixel_out   <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      de          <= de_act;
      pixel_out   <= de_act ? pix : 8'h00;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      frame_start <= at_origin;
      line_start  <= (h == '0) && (int'(v) < V_ACTIVE);
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen on a small 16x8 raster.
module tb_video_stream_gen;

  localparam int HA = 10, HF = 2, HS = 3, HB = 1;
  localparam int VA = 5,  VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
`ifdef VSG_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] pattern_sel;
  logic [7:0] pixel_out;
  logic       hsync, vsync, de, frame_start, line_start;
`ifdef VSG_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  video_stream_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .pixel_out(pixel_out), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .line_start(line_start)
`ifdef VSG_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: raster position within the frame, running flag,
  // pending-stop flag, per-frame pattern and frame count
  bit m_live = 1'b0, m_drain = 1'b0;
  int m_pos = 0, m_pat = 0, m_fc = 0;
  int e_de = 0, e_hs = 0, e_vs = 0, e_pix = 0, e_fs = 0, e_ls = 0, e_fc = 0;

  always @(posedge clk) begin : model_p
    int x, y, fa;
    e_de = 0; e_hs = 0; e_vs = 0; e_pix = 0; e_fs = 0; e_ls = 0;
    if (rst) begin
      m_live = 1'b0; m_drain = 1'b0; m_pos = 0; m_pat = 0; m_fc = 0;
    end else if (!m_live) begin
      if (en) begin
        m_live = 1'b1; m_drain = 1'b0; m_pos = 0;
      end
    end else begin
      if (m_pos == 0) m_pat = int'(pattern_sel);
      x  = m_pos % HT;
      y  = m_pos / HT;
      fa = FC_EN ? m_fc : 0;
      e_de = (x < HA && y < VA) ? 1 : 0;
      e_hs = (x >= HA + HF && x < HA + HF + HS) ? 1 : 0;
      e_vs = (y >= VA + VF && y < VA + VF + VS) ? 1 : 0;
      e_fs = (m_pos == 0) ? 1 : 0;
      e_ls = (x == 0 && y < VA) ? 1 : 0;
      if (e_de == 1) begin
        case (m_pat)
          0: e_pix = (x + y * HA + fa) % 256;
          1: e_pix = ((((x / 8) % 2) != ((y / 8) % 2) ? 255 : 0) + fa) % 256;
          2: e_pix = 128;
          default: e_pix = (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 255 : 0;
        endcase
      end
      if (m_pos == FR - 1) begin
        m_fc = (m_fc + 1) % 256;
        if (m_drain && !en) m_live = 1'b0;
      end
      m_drain = !en;
      m_pos = (m_pos + 1) % FR;
    end
    e_fc = m_fc;
  end

  // Cycle-by-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("de", int'(de), e_de);
    chk("hsync", int'(hsync), e_hs);
    chk("vsync", int'(vsync), e_vs);
    chk("pixel", int'(pixel_out), e_pix);
    chk("frame_start", int'(frame_start), e_fs);
    chk("line_start", int'(line_start), e_ls);
`ifdef VSG_FRAME_CNT_EN
    chk("frame_cnt", int'(frame_cnt), e_fc);
`endif
  end

  int grab_px [64];

  // Sample one whole frame starting at a frame_start sample
  task automatic frame_grab(output int nde, output int nls, output int nhs,
                            output int nvs, output int nfs);
    nde = 0; nls = 0; nhs = 0; nvs = 0;
    for (int i = 0; i < FR; i++) begin
      if (de) begin
        if (nde < 64) grab_px[nde] = int'(pixel_out);
        nde++;
      end
      if (line_start) nls++;
      if (hsync) nhs++;
      if (vsync) nvs++;
      @(negedge clk);
    end
    nfs = int'(frame_start);
  endtask

  task automatic grab_and_check(input string tag);
    int nde, nls, nhs, nvs, nfs;
    frame_grab(nde, nls, nhs, nvs, nfs);
    chk({tag, "_de_count"}, nde, VA * HA);
    chk({tag, "_line_starts"}, nls, VA);
    chk({tag, "_hsync_clocks"}, nhs, HS * VT);
    chk({tag, "_vsync_clocks"}, nvs, HT * VS);
    chk({tag, "_period"}, nfs, 1);
  endtask

  task automatic wait_fs(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 400);
    chk(nm, int'(frame_start), 1);
  endtask

  initial begin : stim
    int n, nf;
    rst = 1'b1; en = 1'b1; pattern_sel = 2'd0;

    // Reset held with en high: everything idle
    repeat (4) begin
      @(negedge clk);
      chk("rst_de", int'(de), 0);
      chk("rst_pix", int'(pixel_out), 0);
      chk("rst_hsync", int'(hsync), 0);
      chk("rst_vsync", int'(vsync), 0);
      chk("rst_fs", int'(frame_start), 0);
    end

    // Start latency: frame_start after the second edge
    rst = 1'b0;
    @(negedge clk);
    chk("start_fs_edge1", int'(frame_start), 0);
    @(negedge clk);
    chk("start_fs_edge2", int'(frame_start), 1);
    chk("start_de_edge2", int'(de), 1);

    grab_and_check("ramp0");
    chk("ramp0_px00", grab_px[0], 0);
    chk("ramp0_px32", grab_px[23], 23);
    grab_and_check("ramp1");
    chk("ramp1_px00", grab_px[0], FC_EN ? 1 : 0);

    // en dropped in line 2: frame completes, then idle
    n = 0; nf = 0;
    for (int i = 0; i < FR + 40; i++) begin
      if (de) n++;
      if (i > 0 && frame_start) nf++;
      if (i == 2 * HT + 4) en = 1'b0;
      @(negedge clk);
    end
    chk("drain_de_count", n, VA * HA);
    chk("drain_no_restart", nf, 0);

    en = 1'b1;
    @(negedge clk);
    chk("restart_fs_edge1", int'(frame_start), 0);
    @(negedge clk);
    chk("restart_fs_edge2", int'(frame_start), 1);

    // Re-assert en while draining: next frame follows with no gap
    for (int i = 0; i < FR; i++) begin
      if (i == 2 * HT + 4) en = 1'b0;
      if (i == 3 * HT + 12) en = 1'b1;
      @(negedge clk);
    end
    chk("b2b_fs", int'(frame_start), 1);

    // pattern_sel 0->3 mid-frame takes effect on the next frame only
    for (int i = 0; i < FR; i++) begin
      if (i == HT + 4) pattern_sel = 2'd3;
      @(negedge clk);
    end
    chk("border_fs", int'(frame_start), 1);
    grab_and_check("border");
    chk("border_px00", grab_px[0], 255);
    chk("border_px42", grab_px[24], 0);
    chk("border_px92", grab_px[29], 255);

    pattern_sel = 2'd1;
    grab_and_check("border2");
    pattern_sel = 2'd2;
    grab_and_check("checker");
`ifndef VSG_FRAME_CNT_EN
    chk("checker_px00", grab_px[0], 0);
    chk("checker_px80", grab_px[8], 255);
`endif
    grab_and_check("flat");
    chk("flat_px31", grab_px[13], 128);

    // Reset mid-frame forces idle and clears the pattern latch
    pattern_sel = 2'd0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_de", int'(de), 0);
      chk("rst_mid_fs", int'(frame_start), 0);
    end
`ifdef VSG_FRAME_CNT_EN
    chk("rst_mid_fc", int'(frame_cnt), 0);
`endif
    rst = 1'b0;
    wait_fs("post_reset_fs");
    grab_and_check("post_reset");
    chk("post_reset_px00", grab_px[0], 0);

`ifdef VSG_FRAME_CNT_EN
    // frame_cnt wraps from 255 to 0
    begin
      int prev;
      bit seen;
      prev = int'(frame_cnt);
      seen = 1'b0;
      for (int i = 0; i < 260 * FR; i++) begin
        @(negedge clk);
        if (prev == 255 && int'(frame_cnt) != 255) begin
          chk("fc_wrap", int'(frame_cnt), 0);
          seen = 1'b1;
          break;
        end
        prev = int'(frame_cnt);
      end
      if (!seen) chk("fc_wrap_timeout", 0, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
